// File: rtl/func_sweep_checker.sv
// func_sweep_checker: exhaustive sweep-and-compare stage for an N_IN-input
// combinational function. Steps vec_out through every input combination,
// compares the function output against a golden ROM bit each cycle, and
// reports mismatch count, first failing vector and pass/done status.
//
// Optional feature: define SWEEP_STOP_ON_FAIL_EN to end the sweep at the
// first mismatch (vec_out then holds the failing vector).
//
// Handshake: start is a level sampled on a rising edge only while the FSM is
// in IDLE or DONE; busy is high for exactly 2^N_IN cycles per sweep, and done
// stays high (with results held) until the next start or reset.
module func_sweep_checker #(
  parameter int N_IN = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_out,
  input  logic            ref_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE  = {{N_IN{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;
  logic            mismatch;

  // The function output and ROM bit both refer to the vector held this cycle.
  assign mismatch = dut_out ^ ref_out;

  // State and result registers; reset clears everything, even mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  // Next-state logic: start from IDLE/DONE clears results; SWEEP compares
  // the current vector, then either advances it or finishes on the last one.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SWEEP;
          vec_d     = '0;
          cnt_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end
      S_SWEEP: begin
        if (mismatch) begin
          // At most 2^N_IN increments per sweep, so N_IN+1 bits never wrap.
          cnt_d = cnt_q + CNT_ONE;
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (mismatch || (vec_q == VEC_LAST)) begin
          state_d = S_DONE;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
`else
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode registered state only, so pass cannot glitch.
  assign vec_out          = vec_q;
  assign busy             = (state_q == S_SWEEP);
  assign done             = (state_q == S_DONE);
  assign pass             = (state_q == S_DONE) && (cnt_q == '0);
  assign mismatch_count   = cnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_func_sweep_checker.sv
// tb_func_sweep_checker: drives func_sweep_checker with a truth-table model
// of the function under test and a golden ROM table, both held as arrays.
// Expected sweep results are computed from the two tables and queued when a
// sweep is issued; a monitor pops and compares them whenever done rises.
module tb_func_sweep_checker;

  localparam int N_IN = 11;
  localparam int NV   = 1 << N_IN;
  localparam int EW   = 41;  // {latency16, count12, first_vec11, valid1, pass1}

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [N_IN-1:0] vec_out;
  logic            dut_out;
  logic            ref_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mismatch_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;
  logic [1:0]      dbg_state;

  bit fut_tt [NV];
  bit rom_tt [NV];

  assign dut_out = fut_tt[vec_out];
  assign ref_out = rom_tt[vec_out];

  func_sweep_checker #(.N_IN(N_IN)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .vec_out          (vec_out),
    .dut_out          (dut_out),
    .ref_out          (ref_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_count   (mismatch_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid),
    .dbg_state_o      (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc = 0;
  logic [EW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: walk the two tables and derive the sweep outcome.
  function automatic logic [EW-1:0] model();
    int cnt = 0;
    int first = 0;
    int lat = NV;
    for (int i = 0; i < NV; i++) begin
      if (fut_tt[i] != rom_tt[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
`ifdef SWEEP_STOP_ON_FAIL_EN
    if (cnt > 0) begin
      cnt = 1;
      lat = first + 1;
    end
`endif
    return {16'(lat), 12'(cnt), 11'((cnt > 0) ? first : 0), (cnt > 0), (cnt == 0)};
  endfunction

  // Scoreboard monitor: compares results on every rising edge of done.
  logic          done_prev = 1'b0;
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no sweep pending");
      end else begin
        mon_e = exp_q.pop_front();
        check("latency",          32'(cyc - start_cyc),    32'(mon_e[40:25]));
        check("mismatch_count",   32'(mismatch_count),     32'(mon_e[24:13]));
        check("first_fail_vec",   32'(first_fail_vec),     32'(mon_e[12:2]));
        check("first_fail_valid", 32'(first_fail_valid),   32'(mon_e[1]));
        check("pass",             32'(pass),               32'(mon_e[0]));
      end
    end
    done_prev = done;
  end

  // Driver tasks
  task automatic fill_random(input int flips);
    for (int i = 0; i < NV; i++) begin
      fut_tt[i] = 1'($urandom_range(0, 1));
      rom_tt[i] = fut_tt[i];
    end
    repeat (flips) rom_tt[$urandom_range(0, NV-1)] ^= 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec_out"},   32'(vec_out),          32'd0);
    check({tag, "_busy"},      32'(busy),             32'd0);
    check({tag, "_done"},      32'(done),             32'd0);
    check({tag, "_pass"},      32'(pass),             32'd0);
    check({tag, "_count"},     32'(mismatch_count),   32'd0);
    check({tag, "_ffv"},       32'(first_fail_vec),   32'd0);
    check({tag, "_ffvalid"},   32'(first_fail_valid), 32'd0);
    check({tag, "_state"},     32'(dbg_state),        32'd0);
  endtask

  task automatic run_sweep(input int repulse_at);
    logic [EW-1:0] e;
    bit seen;
    e = model();
    exp_q.push_back(e);
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 32'(busy),    32'd1);
    check("vec_after_start",  32'(vec_out), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < NV + 16 && !seen; k++) begin
      @(negedge clk);
      start = (repulse_at >= 0 && 32'(vec_out) == repulse_at && busy) ? 1'b1 : 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL sweep_timeout: got no done within %0d cycles, expected done", NV + 16);
    end else begin
      repeat (3) @(negedge clk);
      check("done_hold",  32'(done),           32'd1);
      check("busy_hold",  32'(busy),           32'd0);
      check("count_hold", 32'(mismatch_count), 32'(e[24:13]));
      check("vec_hold",   32'(vec_out),        32'(e[40:25]) - 32'd1);
    end
  endtask

  initial begin
    int hit;
    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // matched tables: full clean sweep
    fill_random(0);
    run_sweep(-1);

    // every vector mismatches
    for (int i = 0; i < NV; i++) rom_tt[i] = ~fut_tt[i];
    run_sweep(-1);

    // single fault at 0x5A3
    for (int i = 0; i < NV; i++) rom_tt[i] = fut_tt[i];
    rom_tt[11'h5A3] ^= 1'b1;
    run_sweep(-1);

    // reset mid-sweep at vec_out == 100, with start held alongside reset
    for (int i = 0; i < NV; i++) rom_tt[i] = ~fut_tt[i];
    pulse_start();
    hit = 0;
    for (int k = 0; k < 200 && hit == 0; k++) begin
      @(negedge clk);
      if (vec_out == 11'd100) hit = 1;
    end
    if (hit == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL reach_vec100: got vec_out=0x%0h, expected 0x64", vec_out);
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    check_all_zero("midreset");
    @(negedge clk);
    check("idle_stays", 32'(busy), 32'd0);
    fill_random(4);
    run_sweep(-1);

    // start re-pulsed at 0x200 is ignored; start in DONE restarts cleanly
    fill_random(5);
    run_sweep(32'h200);
    fill_random(3);
    run_sweep(-1);

    // faults at 0x010 and 0x020
    for (int i = 0; i < NV; i++) rom_tt[i] = fut_tt[i];
    rom_tt[11'h010] ^= 1'b1;
    rom_tt[11'h020] ^= 1'b1;
    run_sweep(-1);

    // randomized sparse-fault sweeps
    repeat (2) begin
      fill_random($urandom_range(0, 8));
      run_sweep(-1);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/func_sweep_checker.md
# func_sweep_checker

Exhaustive sweep-and-compare stage for the 11-input minimized sum-of-products logic block. On `start` it steps an 11-bit vector through all 2048 input combinations and drives them to the function under test. Each cycle it compares the combinational DUT output against a golden truth-table bit supplied by an external ROM addressed by the same vector. It reports a mismatch count, the first failing vector, and pass/done status to the lab harness.

## Interface
Parameters:
- `N_IN`, default 11: number of function inputs and vector width; sweep length is 2^N_IN.

Ports:
- `clk`, input, 1: single clock; every register updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a sweep. Sampled only in IDLE or DONE.
- `vec_out`, output, N_IN: current test vector. Bit N_IN-1 drives `a`; bit 0 drives `k`. Also addresses the golden ROM.
- `dut_out`, input, 1: combinational response of the function under test to `vec_out`.
- `ref_out`, input, 1: combinational golden-ROM bit at address `vec_out`.
- `busy`, output, 1: high in SWEEP.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: `done && mismatch_count == 0`.
- `mismatch_count`, output, N_IN+1: number of mismatching vectors. Wide enough to hold 2^N_IN.
- `first_fail_vec`, output, N_IN: vector of the first mismatch in the current sweep.
- `first_fail_valid`, output, 1: `first_fail_vec` holds a valid value.

## Operation
The checker is a three-state FSM: IDLE, SWEEP, DONE.

- **IDLE**
  - `vec_out` = 0, `busy` = 0, `done` = 0.
  - If `start` = 1: clear `mismatch_count`, `first_fail_valid` and `first_fail_vec`; set `vec_out` = 0; go to SWEEP.
- **SWEEP**, every edge:
  - If `dut_out != ref_out`:
    - Increment `mismatch_count`.
    - If `first_fail_valid` = 0, capture `vec_out` into `first_fail_vec` and set `first_fail_valid` = 1.
  - If `vec_out == 2^N_IN-1`: go to DONE and hold `vec_out`.
  - Otherwise: `vec_out` += 1.
  - `start` is ignored.
- **DONE**
  - All result outputs hold.
  - If `start` = 1: clear results, set `vec_out` = 0, go to SWEEP. This is the same action as from IDLE.
- **Compare rule:** the comparison at an edge always uses the vector visible during the preceding cycle. No vector is skipped or compared twice.
- **Counter width:** `mismatch_count` never wraps. Its maximum is 2^N_IN, which fits in N_IN+1 bits.
- **Reset:** `rst` overrides everything, including mid-sweep. Next state is IDLE, and every output is 0: `vec_out`, `busy`, `done`, `pass`, `mismatch_count`, `first_fail_vec`, `first_fail_valid`.

## Timing
- Let `start` be sampled at edge E0.
- `busy` = 1 and `vec_out` = 0 during the cycle after E0.
- Vector v is compared at edge E(v+1).
- The last vector is compared at E(2^N_IN). At that same edge `busy` falls and `done` rises.
- Sweep latency is exactly 2^N_IN cycles from the start edge; 2048 cycles at the default.
- `dut_out` and `ref_out` must settle within one clock period of a `vec_out` change. No input registering is done.
- `pass` is combinational from registered state and is glitch-free.
- If `start` and `rst` are high together, reset wins.

## Configuration
- **`SWEEP_STOP_ON_FAIL_EN` defined:** the first mismatch ends the sweep.
  - At the edge that detects it: `mismatch_count` = 1 and `first_fail_vec` is captured.
  - The FSM goes straight to DONE, with `vec_out` holding the failing vector.
  - `pass` = 0.
  - If no mismatch occurs, behaviour is identical to the default.
- **Undefined (default):** the full 2^N_IN sweep always runs and every mismatch is counted.

## Test plan
1. `ref_out` tied to `dut_out`, pulse `start` → `busy` for 2048 cycles, then `done` = 1, `pass` = 1, `mismatch_count` = 0, `first_fail_valid` = 0.
2. `ref_out` = ~`dut_out` → `mismatch_count` = 2048 (0x800), `first_fail_vec` = 0x000, `pass` = 0.
3. Golden ROM differs from the DUT only at 0x5A3 → `mismatch_count` = 1, `first_fail_vec` = 0x5A3, `first_fail_valid` = 1.
4. `rst` asserted while `vec_out` = 100 → next cycle all outputs are 0 and the FSM is in IDLE. A following `start` gives a full 2048-cycle sweep.
5. `start` re-pulsed mid-sweep at `vec_out` = 0x200 → ignored, and `done` still rises 2048 cycles after the original start. A `start` in DONE restarts with cleared results.
6. With `SWEEP_STOP_ON_FAIL_EN`, faults at 0x010 and 0x020 → `done` at edge E(0x11), `vec_out` = 0x010, `mismatch_count` = 1, `first_fail_vec` = 0x010.
